// File: rtl/cfg_pkg.sv
// Global configuration shared by the stack blocks.
package cfg_pkg;

  localparam int unsigned ENGS_N = 4;

endpackage : cfg_pkg

// File: rtl/stk_pkg.sv
// Stack-block types: opcodes, INV sequencer state and completion record.
package stk_pkg;

  localparam int unsigned OPCODE_W    = 4;
  localparam logic [OPCODE_W-1:0] OPCODE_INV = 4'h7;

  localparam int unsigned INV_ENGID_W = $clog2(cfg_pkg::ENGS_N);
  localparam int unsigned INV_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    REQ   = 3'd2,
    RSP   = 3'd3,
    DONE  = 3'd4
  } inv_state_t;

  typedef struct packed {
    logic [INV_ENGID_W-1:0] engid;
    logic [INV_CNT_W-1:0]   cnt;
  } inv_done_t;

endpackage : stk_pkg

// File: rtl/stk_inv_seq_cnt.sv
// Saturating up-counter with synchronous clear; increment has priority below clear.
module stk_inv_seq_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : stk_inv_seq_cnt

// File: rtl/stk_inv_seq.sv
// Stack INV opcode sequencer: drains an engine, then issues INV micro-ops
// until its stack reports empty and emits a completion record.
// Optional watchdog abort in RSP: define STK_INV_SEQ_WDOG_EN.
module stk_inv_seq
  import stk_pkg::*;
#(
  parameter int unsigned ENGS_N  = cfg_pkg::ENGS_N,
  parameter int unsigned ENGID_W = $clog2(ENGS_N),
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned WDOG_W  = 12
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_inv_vld,
  input  logic [ENGID_W-1:0] i_inv_engid,
  output logic               o_inv_pop,
  input  logic [ENGS_N-1:0]  i_active,
  output logic               o_req_vld,
  output logic [ENGID_W-1:0] o_req_engid,
  input  logic               i_req_ack,
  input  logic               i_rsp_vld,
  input  logic [ENGID_W-1:0] i_rsp_engid,
  input  logic               i_rsp_freed,
  input  logic               i_rsp_empty,
  output logic [ENGS_N-1:0]  o_blk_d,
  output logic               o_done_vld,
  output logic [ENGID_W-1:0] o_done_engid,
  output logic [CNT_W-1:0]   o_done_cnt,
  output logic               o_err
);

  if (WDOG_W == 0) begin : g_wdog_w_chk
    $error("stk_inv_seq: WDOG_W must be nonzero");
  end

  inv_state_t         state_q;
  inv_state_t         state_d;
  logic [ENGID_W-1:0] engid_q;
  logic [ENGID_W-1:0] engid_d;

  logic               cnt_clr;
  logic               cnt_inc;
  logic [CNT_W-1:0]   cnt;
  logic               rsp_match;
  logic               wdog_hit;
  inv_done_t          done_rec;

  assign rsp_match = i_rsp_vld && (i_rsp_engid == engid_q);

  // Freed-line counter for the command in progress.
  stk_inv_seq_cnt #(
    .W (CNT_W)
  ) u_freed_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt)
  );

`ifdef STK_INV_SEQ_WDOG_EN
  logic              wdog_clr;
  logic              wdog_inc;
  logic [WDOG_W-1:0] wdog;

  assign wdog_clr = (state_q == REQ) && i_req_ack;
  assign wdog_inc = (state_q == RSP);

  // Response watchdog: restarts on every request accept.
  stk_inv_seq_cnt #(
    .W (WDOG_W)
  ) u_wdog_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .clr_i  (wdog_clr),
    .inc_i  (wdog_inc),
    .cnt_o  (wdog)
  );

  assign wdog_hit = (state_q == RSP) && !rsp_match && (wdog == {WDOG_W{1'b1}});
`else
  assign wdog_hit = 1'b0;
`endif

  // State and latched engine id.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= IDLE;
      engid_q <= '0;
    end else begin
      state_q <= state_d;
      engid_q <= engid_d;
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_d     = state_q;
    engid_d     = engid_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    o_inv_pop   = 1'b0;
    o_req_vld   = 1'b0;
    o_req_engid = '0;
    o_blk_d     = '0;
    o_done_vld  = 1'b0;
    done_rec    = '0;

    case (state_q)
      IDLE: begin
        // Hold the queue while reset is asserted so no command is lost.
        o_inv_pop = i_inv_vld && arst_n;
        if (i_inv_vld) begin
          engid_d = i_inv_engid;
          cnt_clr = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        o_blk_d = ENGS_N'(1) << engid_q;
        if (!i_active[engid_q]) begin
          state_d = REQ;
        end
      end
      REQ: begin
        o_blk_d     = ENGS_N'(1) << engid_q;
        o_req_vld   = 1'b1;
        o_req_engid = engid_q;
        if (i_req_ack) begin
          state_d = RSP;
        end
      end
      RSP: begin
        o_blk_d = ENGS_N'(1) << engid_q;
        if (rsp_match) begin
          cnt_inc = i_rsp_freed;
          state_d = i_rsp_empty ? DONE : REQ;
        end else if (wdog_hit) begin
          // Abort: report the partial count alongside the error pulse.
          o_done_vld     = 1'b1;
          done_rec.engid = INV_ENGID_W'(engid_q);
          done_rec.cnt   = INV_CNT_W'(cnt);
          state_d        = IDLE;
        end
      end
      DONE: begin
        o_blk_d        = ENGS_N'(1) << engid_q;
        o_done_vld     = 1'b1;
        done_rec.engid = INV_ENGID_W'(engid_q);
        done_rec.cnt   = INV_CNT_W'(cnt);
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_done_engid = ENGID_W'(done_rec.engid);
  assign o_done_cnt   = CNT_W'(done_rec.cnt);
  assign o_err        = wdog_hit;

  // A response for the target engine is only legal while one is outstanding.
  a_rsp_only_in_rsp : assert property (@(posedge clk) disable iff (!arst_n)
    !(i_rsp_vld && (i_rsp_engid == engid_q) && ((state_q == DRAIN) || (state_q == REQ))));

endmodule : stk_inv_seq

// File: tb/tb_stk_inv_seq.sv
// Directed self-checking bench for stk_inv_seq.
module tb_stk_inv_seq;

  localparam int unsigned ENGS_N  = 4;
  localparam int unsigned ENGID_W = 2;
  localparam int unsigned CNT_W   = 16;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               i_inv_vld;
  logic [ENGID_W-1:0] i_inv_engid;
  logic               o_inv_pop;
  logic [ENGS_N-1:0]  i_active;
  logic               o_req_vld;
  logic [ENGID_W-1:0] o_req_engid;
  logic               i_req_ack;
  logic               i_rsp_vld;
  logic [ENGID_W-1:0] i_rsp_engid;
  logic               i_rsp_freed;
  logic               i_rsp_empty;
  logic [ENGS_N-1:0]  o_blk_d;
  logic               o_done_vld;
  logic [ENGID_W-1:0] o_done_engid;
  logic [CNT_W-1:0]   o_done_cnt;
  logic               o_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stk_inv_seq #(
    .ENGS_N (ENGS_N),
    .CNT_W  (CNT_W),
    .WDOG_W (4)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_inv_vld    (i_inv_vld),
    .i_inv_engid  (i_inv_engid),
    .o_inv_pop    (o_inv_pop),
    .i_active     (i_active),
    .o_req_vld    (o_req_vld),
    .o_req_engid  (o_req_engid),
    .i_req_ack    (i_req_ack),
    .i_rsp_vld    (i_rsp_vld),
    .i_rsp_engid  (i_rsp_engid),
    .i_rsp_freed  (i_rsp_freed),
    .i_rsp_empty  (i_rsp_empty),
    .o_blk_d      (o_blk_d),
    .o_done_vld   (o_done_vld),
    .o_done_engid (o_done_engid),
    .o_done_cnt   (o_done_cnt),
    .o_err        (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop one INV for eng (engine idle) and advance into REQ.
  task automatic start(input logic [ENGID_W-1:0] eng);
    i_inv_vld   = 1'b1;
    i_inv_engid = eng;
    #1;
    chk("pop", 32'(o_inv_pop), 32'd1);
    tick();
    i_inv_vld = 1'b0;
    #1;
    chk("drain_blk", 32'(o_blk_d), 32'd1 << eng);
    chk("drain_noreq", 32'(o_req_vld), 32'd0);
    tick();
  endtask

  // From REQ: ack one cycle late, then answer in RSP.
  task automatic serve(input logic [ENGID_W-1:0] eng, input logic fr, input logic em);
    chk("req_vld", 32'(o_req_vld), 32'd1);
    chk("req_engid", 32'(o_req_engid), 32'(eng));
    tick();
    i_req_ack = 1'b1;
    #1;
    chk("req_hold", 32'(o_req_vld), 32'd1);
    tick();
    i_req_ack = 1'b0;
    #1;
    chk("rsp_noreq", 32'(o_req_vld), 32'd0);
    i_rsp_vld   = 1'b1;
    i_rsp_engid = eng;
    i_rsp_freed = fr;
    i_rsp_empty = em;
    tick();
    i_rsp_vld   = 1'b0;
    i_rsp_freed = 1'b0;
    i_rsp_empty = 1'b0;
    #1;
  endtask

  task automatic chk_done(input logic [ENGID_W-1:0] eng, input int cnt);
    chk("done_vld", 32'(o_done_vld), 32'd1);
    chk("done_engid", 32'(o_done_engid), 32'(eng));
    chk("done_cnt", 32'(o_done_cnt), 32'(cnt));
    chk("done_blk", 32'(o_blk_d), 32'd1 << eng);
  endtask

  initial begin
    arst_n      = 1'b0;
    i_inv_vld   = 1'b1;
    i_inv_engid = 2'd3;
    i_active    = '0;
    i_req_ack   = 1'b0;
    i_rsp_vld   = 1'b0;
    i_rsp_engid = '0;
    i_rsp_freed = 1'b0;
    i_rsp_empty = 1'b0;

    // Reset state: everything low, queue not popped while in reset.
    tick();
    tick();
    chk("rst_pop", 32'(o_inv_pop), 32'd0);
    chk("rst_req", 32'(o_req_vld), 32'd0);
    chk("rst_blk", 32'(o_blk_d), 32'd0);
    chk("rst_done", 32'(o_done_vld), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_inv_vld = 1'b0;
    arst_n    = 1'b1;
    tick();

    // Single INV eng 2, depth 3.
    start(2'd2);
    serve(2'd2, 1'b1, 1'b0);
    serve(2'd2, 1'b1, 1'b0);
    chk("t1_no_early_done", 32'(o_done_vld), 32'd0);
    serve(2'd2, 1'b1, 1'b1);
    chk_done(2'd2, 3);
    tick();
    chk("t1_idle_done", 32'(o_done_vld), 32'd0);
    chk("t1_idle_blk", 32'(o_blk_d), 32'd0);

    // INV eng 1 blocked by in-flight op for 5 cycles; eng 0 activity irrelevant.
    i_active    = 4'b0010;
    i_inv_vld   = 1'b1;
    i_inv_engid = 2'd1;
    #1;
    chk("t2_pop", 32'(o_inv_pop), 32'd1);
    tick();
    i_inv_vld = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_active[0] = ~i_active[0];
      #1;
      chk("t2_wait_noreq", 32'(o_req_vld), 32'd0);
      chk("t2_wait_blk", 32'(o_blk_d), 32'b0010);
      tick();
    end
    i_active = 4'b0001;
    #1;
    chk("t2_clear_noreq", 32'(o_req_vld), 32'd0);
    tick();
    i_active = '0;
    serve(2'd1, 1'b1, 1'b1);
    chk_done(2'd1, 1);
    tick();

    // Empty stack on entry, eng 0.
    start(2'd0);
    serve(2'd0, 1'b0, 1'b1);
    chk_done(2'd0, 0);
    tick();

    // Two queued INVs for eng 3 (depth 2, then depth 1).
    i_inv_vld   = 1'b1;
    i_inv_engid = 2'd3;
    #1;
    chk("t4_pop1", 32'(o_inv_pop), 32'd1);
    tick();
    #1;
    chk("t4_busy_nopop", 32'(o_inv_pop), 32'd0);
    tick();
    serve(2'd3, 1'b1, 1'b0);
    serve(2'd3, 1'b1, 1'b1);
    chk_done(2'd3, 2);
    chk("t4_done_nopop", 32'(o_inv_pop), 32'd0);
    tick();
    chk("t4_pop2", 32'(o_inv_pop), 32'd1);
    tick();
    i_inv_vld = 1'b0;
    tick();
    serve(2'd3, 1'b1, 1'b1);
    chk_done(2'd3, 1);
    tick();

    // Foreign response ignored while servicing eng 2.
    start(2'd2);
    chk("t5_req", 32'(o_req_vld), 32'd1);
    i_req_ack = 1'b1;
    tick();
    i_req_ack   = 1'b0;
    i_rsp_vld   = 1'b1;
    i_rsp_engid = 2'd1;
    i_rsp_freed = 1'b1;
    i_rsp_empty = 1'b1;
    tick();
    i_rsp_vld = 1'b0;
    #1;
    chk("t5_foreign_nodone", 32'(o_done_vld), 32'd0);
    chk("t5_foreign_noreq", 32'(o_req_vld), 32'd0);
    i_rsp_vld   = 1'b1;
    i_rsp_engid = 2'd2;
    i_rsp_empty = 1'b0;
    tick();
    i_rsp_vld   = 1'b0;
    i_rsp_freed = 1'b0;
    #1;
    serve(2'd2, 1'b1, 1'b1);
    chk_done(2'd2, 2);
    tick();

    // Reset while a response is outstanding; the late response is dropped.
    start(2'd2);
    i_req_ack = 1'b1;
    tick();
    i_req_ack = 1'b0;
    arst_n    = 1'b0;
    tick();
    chk("t6_rst_req", 32'(o_req_vld), 32'd0);
    chk("t6_rst_blk", 32'(o_blk_d), 32'd0);
    chk("t6_rst_done", 32'(o_done_vld), 32'd0);
    chk("t6_rst_cnt", 32'(o_done_cnt), 32'd0);
    arst_n      = 1'b1;
    i_rsp_vld   = 1'b1;
    i_rsp_engid = 2'd2;
    i_rsp_freed = 1'b1;
    i_rsp_empty = 1'b1;
    tick();
    i_rsp_vld   = 1'b0;
    i_rsp_freed = 1'b0;
    i_rsp_empty = 1'b0;
    #1;
    chk("t6_late_nodone", 32'(o_done_vld), 32'd0);
    chk("t6_late_blk", 32'(o_blk_d), 32'd0);
    tick();
    chk("t6_late_nodone2", 32'(o_done_vld), 32'd0);

`ifdef STK_INV_SEQ_WDOG_EN
    // Watchdog: one line freed, then silence until abort with partial count.
    start(2'd1);
    serve(2'd1, 1'b1, 1'b0);
    i_req_ack = 1'b1;
    tick();
    i_req_ack = 1'b0;
    begin
      int n;
      n = 0;
      while (!o_err && n < 40) begin
        tick();
        n++;
      end
      chk("wd_cycles", 32'(n), 32'd15);
      chk("wd_err", 32'(o_err), 32'd1);
      chk("wd_done", 32'(o_done_vld), 32'd1);
      chk("wd_cnt", 32'(o_done_cnt), 32'd1);
    end
    tick();
    chk("wd_idle_blk", 32'(o_blk_d), 32'd0);
    chk("wd_idle_err", 32'(o_err), 32'd0);
`else
    chk("err_tied", 32'(o_err), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_stk_inv_seq
